dot_product_accumulator: RTL and testbench

DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

---
 rtl/dot_product_accumulator.sv | 103 ++++++++++
 tb/tb_dot_product_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accumulator.sv
// Streaming dot-product accumulator: sums VEC_LEN signed products per result.
// Define DOT_ACC_SATURATE_EN for clamping arithmetic; default build wraps.
module dot_product_accumulator #(
  parameter int IN_WIDTH  = 10,
  parameter int VEC_LEN   = 8,
  parameter int ACC_WIDTH = 2*IN_WIDTH+4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          inReady,
  input  logic signed [2*IN_WIDTH-1:0]  DP,
  output logic                          outReady,
  output logic signed [ACC_WIDTH-1:0]   ACC,
  output logic                          busy,
  output logic                          overflow
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN-1);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

`ifdef DOT_ACC_SATURATE_EN
  localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  acc_t             acc_q, acc_d, acc_base;
  acc_t             res_q, res_d;
  acc_t             dp_ext, sum_wrap, sum;
  logic             ovf_q, ovf_d, ovf_base, add_ovf;
  logic             out_ready_q, out_ready_d;
  logic             overflow_q, overflow_d;
  logic             restart;

  always_comb begin
    dp_ext  = acc_t'(DP);
    // A clear with a valid product, or an idle counter, starts a fresh vector.
    restart  = clear || (cnt_q == '0);
    cnt_base = restart ? '0 : cnt_q;
    acc_base = restart ? '0 : acc_q;
    ovf_base = restart ? 1'b0 : ovf_q;

    sum_wrap = acc_base + dp_ext;
    add_ovf  = (acc_base[ACC_WIDTH-1] == dp_ext[ACC_WIDTH-1]) &&
               (sum_wrap[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
`ifdef DOT_ACC_SATURATE_EN
    sum = add_ovf ? (acc_base[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum_wrap;
`else
    sum = sum_wrap;
`endif

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    res_d       = res_q;
    overflow_d  = overflow_q;
    out_ready_d = 1'b0;

    if (inReady) begin
      acc_d = sum;
      ovf_d = ovf_base | add_ovf;
      if (cnt_base == LAST) begin
        cnt_d       = '0;
        res_d       = sum;
        overflow_d  = ovf_base | add_ovf;
        out_ready_d = 1'b1;
      end else begin
        cnt_d = cnt_base + CNT_W'(1);
      end
    end else if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_q       <= '0;
      overflow_q  <= 1'b0;
      out_ready_q <= 1'b0;
    end else if (enable) begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      res_q       <= res_d;
      overflow_q  <= overflow_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign outReady = out_ready_q;
  assign ACC      = res_q;
  assign overflow = overflow_q;
  assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench for dot_product_accumulator: three instances (VEC_LEN=4 wide,
// narrow 8-bit accumulator, VEC_LEN=1) checked against an expected-result queue.
module tb_dot_product_accumulator;

  typedef struct {
    int   acc;
    logic ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // instance A: IN_WIDTH=10, VEC_LEN=4, ACC_WIDTH=24
  logic                a_rst_n, a_en, a_clr, a_in;
  logic signed [19:0]  a_dp;
  logic                a_out, a_busy, a_ovf;
  logic signed [23:0]  a_acc;

  // instance B: IN_WIDTH=4, ACC_WIDTH=8, VEC_LEN=4
  logic                bc_rst_n;
  logic                b_en, b_clr, b_in;
  logic signed [7:0]   b_dp;
  logic                b_out, b_busy, b_ovf;
  logic signed [7:0]   b_acc;

  // instance C: IN_WIDTH=10, VEC_LEN=1
  logic                c_en, c_clr, c_in, c_en_last;
  logic signed [19:0]  c_dp;
  logic                c_out, c_busy, c_ovf;
  logic signed [23:0]  c_acc;

  dot_product_accumulator #(.IN_WIDTH(10), .VEC_LEN(4)) u_a (
    .clk(clk), .reset(a_rst_n), .enable(a_en), .clear(a_clr), .inReady(a_in),
    .DP(a_dp), .outReady(a_out), .ACC(a_acc), .busy(a_busy), .overflow(a_ovf));

  dot_product_accumulator #(.IN_WIDTH(4), .VEC_LEN(4), .ACC_WIDTH(8)) u_b (
    .clk(clk), .reset(bc_rst_n), .enable(b_en), .clear(b_clr), .inReady(b_in),
    .DP(b_dp), .outReady(b_out), .ACC(b_acc), .busy(b_busy), .overflow(b_ovf));

  dot_product_accumulator #(.IN_WIDTH(10), .VEC_LEN(1)) u_c (
    .clk(clk), .reset(bc_rst_n), .enable(c_en), .clear(c_clr), .inReady(c_in),
    .DP(c_dp), .outReady(c_out), .ACC(c_acc), .busy(c_busy), .overflow(c_ovf));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_a(input int acc, input logic ovf);
    exp_t e;
    e.acc = acc;
    e.ovf = ovf;
    qa.push_back(e);
  endtask

  task automatic feed_a(input int v);
    a_in = 1'b1;
    a_dp = 20'(v);
    tick();
  endtask

  task automatic feed_b(input int v);
    b_in = 1'b1;
    b_dp = 8'(v);
    tick();
  endtask

  always @(posedge clk) c_en_last <= c_en;

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_out) begin
      if (qa.size() == 0) chk("a_unexpected_pulse", 32'(a_out), 32'(0));
      else begin
        e = qa.pop_front();
        chk("a_acc", 32'(a_acc), e.acc);
        chk("a_ovf", 32'(a_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_out) begin
      if (qb.size() == 0) chk("b_unexpected_pulse", 32'(b_out), 32'(0));
      else begin
        e = qb.pop_front();
        chk("b_acc", 32'(b_acc), e.acc);
        chk("b_ovf", 32'(b_ovf), 32'(e.ovf));
      end
    end
  end

  // C completes on every enabled accepting edge; held pulses are checked inline.
  always @(negedge clk) begin : mon_c
    exp_t e;
    if (c_out && c_en_last) begin
      if (qc.size() == 0) chk("c_unexpected_pulse", 32'(c_out), 32'(0));
      else begin
        e = qc.pop_front();
        chk("c_acc", 32'(c_acc), e.acc);
        chk("c_ovf", 32'(c_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    exp_t e;
    a_rst_n = 1'b0; a_en = 1'b1; a_clr = 1'b0; a_in = 1'b0; a_dp = '0;
    bc_rst_n = 1'b0; b_en = 1'b1; b_clr = 1'b0; b_in = 1'b0; b_dp = '0;
    c_en = 1'b1; c_clr = 1'b0; c_in = 1'b0; c_dp = '0;
    tick(2);
    chk("rst_a_out", 32'(a_out), 32'(0));
    chk("rst_a_acc", 32'(a_acc), 32'(0));
    chk("rst_a_busy", 32'(a_busy), 32'(0));
    chk("rst_a_ovf", 32'(a_ovf), 32'(0));
    a_rst_n = 1'b1;
    bc_rst_n = 1'b1;
    tick();

    // basic vector 3,-5,7,10
    push_a(15, 1'b0);
    feed_a(3);
    chk("t1_busy", 32'(a_busy), 32'(1));
    feed_a(-5); feed_a(7); feed_a(10);
    a_in = 1'b0;
    chk("t1_out", 32'(a_out), 32'(1));
    chk("t1_busy_done", 32'(a_busy), 32'(0));
    tick();
    chk("t1_out_cleared", 32'(a_out), 32'(0));

    // gap inside vector
    push_a(10, 1'b0);
    feed_a(1);
    chk("t2_busy_first", 32'(a_busy), 32'(1));
    feed_a(2);
    a_in = 1'b0;
    tick(5);
    chk("t2_busy_gap", 32'(a_busy), 32'(1));
    chk("t2_no_early_pulse", 32'(a_out), 32'(0));
    feed_a(3); feed_a(4);
    a_in = 1'b0;
    chk("t2_busy_done", 32'(a_busy), 32'(0));
    tick(2);

    // clear with a valid product restarts the vector
    push_a(8, 1'b0);
    feed_a(9); feed_a(9);
    a_clr = 1'b1;
    feed_a(2);
    a_clr = 1'b0;
    feed_a(2); feed_a(2); feed_a(2);
    a_in = 1'b0;
    tick(2);

    // clear alone drops the partial vector
    push_a(10, 1'b0);
    feed_a(7);
    a_in = 1'b0; a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("t3b_busy_after_clear", 32'(a_busy), 32'(0));
    feed_a(1); feed_a(2); feed_a(3); feed_a(4);
    a_in = 1'b0;
    tick(2);

    // disabled edge ignores a valid product
    push_a(6, 1'b0);
    feed_a(1);
    a_en = 1'b0;
    feed_a(100);
    a_en = 1'b1;
    feed_a(1); feed_a(1); feed_a(3);
    a_in = 1'b0;
    tick(2);

    // asynchronous reset mid-vector
    push_a(4, 1'b0);
    feed_a(5); feed_a(5);
    a_in = 1'b0;
    #2 a_rst_n = 1'b0;
    #1;
    chk("t4_rst_out", 32'(a_out), 32'(0));
    chk("t4_rst_acc", 32'(a_acc), 32'(0));
    chk("t4_rst_busy", 32'(a_busy), 32'(0));
    chk("t4_rst_ovf", 32'(a_ovf), 32'(0));
    tick();
    a_rst_n = 1'b1;
    feed_a(1); feed_a(1); feed_a(1); feed_a(1);
    a_in = 1'b0;
    tick(2);

    // narrow accumulator overflow, then a clean vector
`ifdef DOT_ACC_SATURATE_EN
    e.acc = 127;
`else
    e.acc = 0;
`endif
    e.ovf = 1'b1;
    qb.push_back(e);
    e.acc = 10;
    e.ovf = 1'b0;
    qb.push_back(e);
    feed_b(64); feed_b(64); feed_b(64); feed_b(64);
    feed_b(1); feed_b(2); feed_b(3); feed_b(4);
    b_in = 1'b0;
    tick(2);

    // VEC_LEN=1 with enable toggling
    e.acc = -6;
    e.ovf = 1'b0;
    qc.push_back(e);
    qc.push_back(e);
    c_in = 1'b1;
    c_dp = 20'(-6);
    tick();
    chk("t6_out_first", 32'(c_out), 32'(1));
    chk("t6_acc_first", 32'(c_acc), -32'sd6);
    c_en = 1'b0;
    tick();
    chk("t6_out_held", 32'(c_out), 32'(1));
    chk("t6_busy_held", 32'(c_busy), 32'(0));
    c_en = 1'b1;
    tick();
    chk("t6_out_second", 32'(c_out), 32'(1));
    c_in = 1'b0;
    tick();
    chk("t6_out_cleared", 32'(c_out), 32'(0));
    tick(2);

    chk("qa_drained", 32'(qa.size()), 32'(0));
    chk("qb_drained", 32'(qb.size()), 32'(0));
    chk("qc_drained", 32'(qc.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
